// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, load-size encoding and size decode for the MEM/WB stage.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF     = 64;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int PC_W_DEF       = 64;

    // One-hot bit positions of the load size field
    localparam int SIZE_B = 0;
    localparam int SIZE_H = 1;
    localparam int SIZE_W = 2;
    localparam int SIZE_D = 3;

    typedef enum logic [1:0] {
        LD_SEL_B = 2'd0,
        LD_SEL_H = 2'd1,
        LD_SEL_W = 2'd2,
        LD_SEL_D = 2'd3
    } ld_sel_e;

    // Narrowest set bit wins; an all-zero size falls through to a full dword.
    function automatic ld_sel_e decode_size(input logic [3:0] size);
        if (size[SIZE_B])      return LD_SEL_B;
        else if (size[SIZE_H]) return LD_SEL_H;
        else if (size[SIZE_W]) return LD_SEL_W;
        else                   return LD_SEL_D;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_data_align.sv
// Extracts, right-aligns and extends a B/H/W/D field from a raw 8-byte-aligned dword.
module load_data_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_raw,
    input  logic [2:0]        i_offset,
    input  logic [3:0]        i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_aligned
);

    logic [5:0]  w_shamt;
    logic [31:0] w_sh;
    logic        w_ext;

    assign w_shamt = {i_offset, 3'b000};
    // Only the low word of the shifted dword can ever be selected; fields that run off the top are truncated.
    assign w_sh    = 32'(i_raw >> w_shamt);

    always_comb begin
        o_aligned = i_raw;
        w_ext     = 1'b0;
        case (decode_size(i_size))
            LD_SEL_B: begin
                w_ext     = ~i_unsigned & w_sh[7];
                o_aligned = {{(DATA_W-8){w_ext}}, w_sh[7:0]};
            end
            LD_SEL_H: begin
                w_ext     = ~i_unsigned & w_sh[15];
                o_aligned = {{(DATA_W-16){w_ext}}, w_sh[15:0]};
            end
            LD_SEL_W: begin
                w_ext     = ~i_unsigned & w_sh[31];
                o_aligned = {{(DATA_W-32){w_ext}}, w_sh[31:0]};
            end
            default: o_aligned = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures retiring results, aligns load data, drives writeback and forwarding.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int PC_W       = PC_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  mem_stall,
    input  logic                  mem_valid,
    input  logic [PC_W-1:0]       mem_pc,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_rd_wen,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic                  mem_is_load,
    input  logic [2:0]            mem_ls_offset,
    input  logic [3:0]            mem_ls_size,
    input  logic                  mem_ls_unsigned,
    input  logic                  opload_operation_done,
    input  logic [DATA_W-1:0]     opload_read_data,
    output logic                  wb_valid,
    output logic [PC_W-1:0]       wb_pc,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_rd_wen,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  load_err
);

    logic [DATA_W-1:0]     w_aligned;
    logic [DATA_W-1:0]     w_result;
    logic                  w_load_miss;
    logic                  w_rd_wen;

    logic                  r_wb_valid;
    logic [PC_W-1:0]       r_wb_pc;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_wb_rd_wen;
    logic [DATA_W-1:0]     r_wb_data;
    logic                  r_load_err;

    load_data_align #(.DATA_W(DATA_W)) u_align (
        .i_raw      (opload_read_data),
        .i_offset   (mem_ls_offset),
        .i_size     (mem_ls_size),
        .i_unsigned (mem_ls_unsigned),
        .o_aligned  (w_aligned)
    );

    // Load data is only valid in the done cycle; a load retiring without it writes zero.
    assign w_load_miss = mem_valid & mem_is_load & ~opload_operation_done;
    assign w_result    = ~mem_is_load           ? mem_alu_result :
                         opload_operation_done  ? w_aligned      : '0;
    assign w_rd_wen    = mem_valid & mem_rd_wen & (mem_rd != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_valid  <= 1'b0;
            r_wb_pc     <= '0;
            r_wb_rd     <= '0;
            r_wb_rd_wen <= 1'b0;
            r_wb_data   <= '0;
            r_load_err  <= 1'b0;
        end else if (flush || mem_stall) begin
            // Squash or bubble: data fields hold their last value.
            r_wb_valid  <= 1'b0;
            r_wb_rd_wen <= 1'b0;
        end else begin
            r_wb_valid  <= mem_valid;
            r_wb_pc     <= mem_pc;
            r_wb_rd     <= mem_rd;
            r_wb_rd_wen <= w_rd_wen;
            r_wb_data   <= w_result;
            if (w_load_miss) r_load_err <= 1'b1;
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_pc     = r_wb_pc;
    assign wb_rd     = r_wb_rd;
    assign wb_rd_wen = r_wb_rd_wen;
    assign wb_data   = r_wb_data;
    assign fwd_valid = r_wb_rd_wen;
    assign fwd_rd    = r_wb_rd;
    assign fwd_data  = r_wb_data;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expected values.
module tb_mem_wb_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        mem_stall;
    logic        mem_valid;
    logic [63:0] mem_pc;
    logic [4:0]  mem_rd;
    logic        mem_rd_wen;
    logic [63:0] mem_alu_result;
    logic        mem_is_load;
    logic [2:0]  mem_ls_offset;
    logic [3:0]  mem_ls_size;
    logic        mem_ls_unsigned;
    logic        opload_operation_done;
    logic [63:0] opload_read_data;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_rd_wen;
    logic [63:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_wb_stage dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .flush                 (flush),
        .mem_stall             (mem_stall),
        .mem_valid             (mem_valid),
        .mem_pc                (mem_pc),
        .mem_rd                (mem_rd),
        .mem_rd_wen            (mem_rd_wen),
        .mem_alu_result        (mem_alu_result),
        .mem_is_load           (mem_is_load),
        .mem_ls_offset         (mem_ls_offset),
        .mem_ls_size           (mem_ls_size),
        .mem_ls_unsigned       (mem_ls_unsigned),
        .opload_operation_done (opload_operation_done),
        .opload_read_data      (opload_read_data),
        .wb_valid              (wb_valid),
        .wb_pc                 (wb_pc),
        .wb_rd                 (wb_rd),
        .wb_rd_wen             (wb_rd_wen),
        .wb_data               (wb_data),
        .fwd_valid             (fwd_valid),
        .fwd_rd                (fwd_rd),
        .fwd_data              (fwd_data),
        .load_err              (load_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string what);
        @(posedge clock);
        #1;
        $display("t=%0t %s: wb_valid=%0b rd=%0d wen=%0b data=%h err=%0b",
                 $time, what, wb_valid, wb_rd, wb_rd_wen, wb_data, load_err);
    endtask

    task automatic drive_alu(input logic v, input logic [63:0] pc, input logic [4:0] rd,
                             input logic [63:0] alu);
        mem_valid = v; mem_pc = pc; mem_rd = rd; mem_rd_wen = 1'b1;
        mem_alu_result = alu; mem_is_load = 1'b0; opload_operation_done = 1'b0;
        mem_ls_offset = 3'd0; mem_ls_size = 4'b1000; mem_ls_unsigned = 1'b0;
        opload_read_data = 64'h0;
    endtask

    task automatic drive_load(input logic [63:0] pc, input logic [4:0] rd, input logic [2:0] off,
                              input logic [3:0] size, input logic uns, input logic [63:0] raw,
                              input logic done);
        mem_valid = 1'b1; mem_pc = pc; mem_rd = rd; mem_rd_wen = 1'b1;
        mem_alu_result = 64'hA5A5_A5A5_A5A5_A5A5; mem_is_load = 1'b1;
        mem_ls_offset = off; mem_ls_size = size; mem_ls_unsigned = uns;
        opload_read_data = raw; opload_operation_done = done;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 64'(wb_valid), 64'd0);
        chk({tag, ".pc"}, wb_pc, 64'd0);
        chk({tag, ".rd"}, 64'(wb_rd), 64'd0);
        chk({tag, ".wen"}, 64'(wb_rd_wen), 64'd0);
        chk({tag, ".data"}, wb_data, 64'd0);
        chk({tag, ".fvalid"}, 64'(fwd_valid), 64'd0);
        chk({tag, ".frd"}, 64'(fwd_rd), 64'd0);
        chk({tag, ".fdata"}, fwd_data, 64'd0);
        chk({tag, ".err"}, 64'(load_err), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        drive_alu(1'b1, 64'h100, 5'd1, 64'hFFFF);
        step("reset");
        step("reset");
        chk_all_zero("reset");
        reset_n = 1'b1;

        // LB offset 5: byte 0x80 sign-extended
        drive_load(64'h200, 5'd3, 3'd5, 4'b0001, 1'b0, 64'h0000_80AA_0000_0000, 1'b1);
        step("lb");
        chk("lb.data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb.wen", 64'(wb_rd_wen), 64'd1);
        chk("lb.valid", 64'(wb_valid), 64'd1);
        chk("lb.pc", wb_pc, 64'h200);
        chk("lb.rd", 64'(wb_rd), 64'd3);
        chk("lb.fdata", fwd_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb.fvalid", 64'(fwd_valid), 64'd1);
        chk("lb.frd", 64'(fwd_rd), 64'd3);
        chk("lb.err", 64'(load_err), 64'd0);

        drive_load(64'h204, 5'd4, 3'd6, 4'b0010, 1'b1, 64'hBEEF_0000_0000_0000, 1'b1);
        step("lhu");
        chk("lhu.data", wb_data, 64'h0000_0000_0000_BEEF);

        drive_load(64'h208, 5'd5, 3'd4, 4'b0100, 1'b0, 64'h8000_0001_1234_5678, 1'b1);
        step("lw");
        chk("lw.data", wb_data, 64'hFFFF_FFFF_8000_0001);

        drive_load(64'h20C, 5'd5, 3'd4, 4'b0100, 1'b1, 64'h8000_0001_1234_5678, 1'b1);
        step("lwu");
        chk("lwu.data", wb_data, 64'h0000_0000_8000_0001);

        // All-zero size acts as a dword; offset ignored
        drive_load(64'h210, 5'd6, 3'd3, 4'b0000, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
        step("ld0");
        chk("ld0.data", wb_data, 64'h0123_4567_89AB_CDEF);

        // W beats D when both set
        drive_load(64'h214, 5'd6, 3'd0, 4'b1100, 1'b0, 64'h1122_3344_F566_7788, 1'b1);
        step("lwd");
        chk("lwd.data", wb_data, 64'hFFFF_FFFF_F566_7788);

        drive_alu(1'b1, 64'h300, 5'd7, 64'hDEAD);
        step("alu");
        chk("alu.valid", 64'(wb_valid), 64'd1);
        chk("alu.data", wb_data, 64'hDEAD);

        drive_alu(1'b1, 64'h304, 5'd8, 64'hBEEF);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk($sformatf("stall%0d.valid", i), 64'(wb_valid), 64'd0);
            chk($sformatf("stall%0d.fvalid", i), 64'(fwd_valid), 64'd0);
            chk($sformatf("stall%0d.hold", i), wb_data, 64'hDEAD);
        end
        mem_stall = 1'b0;
        step("unstall");
        chk("unstall.valid", 64'(wb_valid), 64'd1);
        chk("unstall.data", wb_data, 64'hBEEF);
        chk("unstall.rd", 64'(wb_rd), 64'd8);

        // Flush coincides with load completion: load result dropped
        drive_load(64'h308, 5'd9, 3'd0, 4'b1000, 1'b0, 64'h1111_2222_3333_4444, 1'b1);
        flush = 1'b1;
        step("flush");
        chk("flush.valid", 64'(wb_valid), 64'd0);
        chk("flush.wen", 64'(wb_rd_wen), 64'd0);
        chk("flush.hold", wb_data, 64'hBEEF);
        flush = 1'b0;

        drive_alu(1'b1, 64'h30C, 5'd0, 64'h1234);
        step("rd0");
        chk("rd0.valid", 64'(wb_valid), 64'd1);
        chk("rd0.wen", 64'(wb_rd_wen), 64'd0);
        chk("rd0.fvalid", 64'(fwd_valid), 64'd0);
        chk("rd0.data", wb_data, 64'h1234);

        // Load retiring without done
        drive_load(64'h310, 5'd10, 3'd0, 4'b1000, 1'b0, 64'h9999_9999_9999_9999, 1'b0);
        step("miss");
        chk("miss.valid", 64'(wb_valid), 64'd1);
        chk("miss.data", wb_data, 64'd0);
        chk("miss.err", 64'(load_err), 64'd1);

        drive_alu(1'b1, 64'h314, 5'd11, 64'h77);
        step("sticky");
        chk("sticky.err", 64'(load_err), 64'd1);
        chk("sticky.data", wb_data, 64'h77);

        // Reset asserted mid-cycle while stalled
        mem_stall = 1'b1;
        step("stall2");
        #2;
        reset_n = 1'b0;
        #1;
        $display("t=%0t async reset: wb_valid=%0b data=%h err=%0b", $time, wb_valid, wb_data, load_err);
        chk_all_zero("areset");
        #1;
        reset_n = 1'b1;
        step("post-reset");
        chk("postrst.err", 64'(load_err), 64'd0);
        chk("postrst.valid", 64'(wb_valid), 64'd0);
        mem_stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
